// File: rtl/alu_exec_unit.sv
// Registered 16-bit execute unit with valid/ready on both sides.
// Define MULT_EN to build in the 16-cycle unsigned shift-add multiplier (code 101).
module alu_exec_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

`ifdef MULT_EN
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [2:0]  OP_MUL = 3'b101;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   partial_c;
  logic            start_mul_c;
`endif

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic             accept_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_ovf_c;

  // A new op may enter only when idle and the output slot is free or being drained
`ifdef MULT_EN
  assign in_ready    = reset_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign start_mul_c = (alu_control == OP_MUL);
  assign partial_c   = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
`else
  assign in_ready    = reset_n && (!out_valid_q || out_ready);
`endif
  assign accept_c = in_valid && in_ready;
  assign sum_c    = a + b;
  assign diff_c   = a - b;

  // Single-cycle datapath; unlisted codes (and 101 without the multiplier) fall to add
  always_comb begin
    alu_res_c = sum_c;
    alu_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
    case (alu_control)
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: begin
        alu_res_c = a & b;
        alu_ovf_c = 1'b0;
      end
      OP_OR: begin
        alu_res_c = a | b;
        alu_ovf_c = 1'b0;
      end
      OP_SLT: begin
        alu_res_c = ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
        alu_ovf_c = 1'b0;
      end
      default: ;
    endcase
  end

  // Next-state and output-register logic
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
`ifdef MULT_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;

    if (accept_c && !start_mul_c) begin
      result_d    = alu_res_c;
      zero_d      = (alu_res_c == '0);
      overflow_d  = alu_ovf_c;
      out_valid_d = 1'b1;
    end

    if (accept_c && start_mul_c) begin
      mcand_d  = PW'(a);
      mplier_d = b;
      acc_d    = '0;
      count_d  = '0;
      state_d  = S_MUL;
    end

    if (state_q == S_MUL) begin
      acc_d    = partial_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      if (count_q == CW'(WIDTH - 1)) begin
        result_d    = partial_c[WIDTH-1:0];
        zero_d      = (partial_c[WIDTH-1:0] == '0);
        overflow_d  = |partial_c[PW-1:WIDTH];
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
    end
`else
    if (accept_c) begin
      result_d    = alu_res_c;
      zero_d      = (alu_res_c == '0);
      overflow_d  = alu_ovf_c;
      out_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef MULT_EN
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
`ifdef MULT_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every out_valid && out_ready.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        o;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        overflow;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every consumed output must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", 32'(result), 32'(e.r));
        chk("sb_zero", 32'(zero), 32'(e.z));
        chk("sb_overflow", 32'(overflow), 32'(e.o));
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge
  task automatic issue(input logic [2:0] op, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] er, input logic ez, input logic eo);
    bit acc;
    exp_t e;
    acc = 1'b0;
    in_valid = 1'b1;
    alu_control = op;
    a = ia;
    b = ib;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (acc) begin
      e.r = er;
      e.z = ez;
      e.o = eo;
      sb.push_back(e);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: op %b never accepted, required accept within 64 cycles", op);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle, check cleared outputs, then release
  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

  initial begin
    int k;
    reset_n = 1'b0;
    in_valid = 1'b0;
    alu_control = 3'b000;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_result", 32'(result), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("init_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Add/sub overflow, one result per cycle
    issue(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    issue(3'b001, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0);
    issue(3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    issue(3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    issue(3'b001, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
    // Signed less-than
    issue(3'b100, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    issue(3'b100, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    issue(3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0);
    issue(3'b111, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0);
    issue(3'b110, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    drain();

    // Backpressure: hold result three cycles, then consume and accept on one edge
    out_ready = 1'b0;
    issue(3'b010, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result_held", 32'(result), 32'h000F);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(3'b011, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_same_edge_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Reset mid-stream with an unconsumed result
    out_ready = 1'b0;
    issue(3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    do_reset();
    out_ready = 1'b1;

`ifdef MULT_EN
    issue(3'b101, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (out_valid) k = i;
    end
    chk("mul_latency", 32'(k), 32'd16);
    @(posedge clk);
    #1;
    issue(3'b101, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
    drain();

    // Reset at multiply cycle 8 aborts it
    issue(3'b101, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("mul_abort_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
`else
    issue(3'b101, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
    @(negedge clk);
    chk("code101_latency", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
`endif

    issue(3'b000, 16'h0002, 16'h0002, 16'h0004, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_add_latency", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered 16-bit execute unit for the MIPS16 datapath, directly downstream of the ALU control decoder: it consumes the 3-bit ALU control code and two operands, and returns result, zero and overflow flags. It uses a valid/ready handshake on both sides so the pipeline can stall. A multi-cycle shift-add multiplier can be compiled in.

## Interface
- WIDTH, 16: operand/result width; only 16 is supported.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept an operation this cycle
- alu_control  input  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul (MULT_EN only); others are add
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- overflow  output  1  signed overflow (add/sub), or nonzero high half (mul)

## Operation
- States: IDLE, MUL. Reset state is IDLE.
- in_ready = reset_n && state==IDLE && (!out_valid || out_ready).
- An operation is accepted on a rising edge with in_valid && in_ready. a, b and alu_control are sampled only then.
- Single-cycle ops (any code except 101 with MULT_EN):
  - result, zero and overflow are written on the accept edge.
  - out_valid is set and the state stays IDLE.
  - add: a+b mod 2^16; overflow = operand signs equal and result sign differs.
  - sub: a-b mod 2^16; overflow = operand signs differ and result sign differs from a.
  - and / or: bitwise; overflow = 0.
  - slt: signed a<b gives 16'h0001, else 16'h0000; overflow = 0.
- mul (MULT_EN):
  - On accept, load the multiplicand (zero-extended to 32 bits) and the multiplier b, clear the 32-bit accumulator, set count=0, and go to MUL.
  - In MUL, each cycle: if the multiplier LSB = 1, add the multiplicand to the accumulator. Then shift the multiplicand left, shift the multiplier right, and increment count.
  - On the cycle where count==15 completes: result = acc[15:0], overflow = |acc[31:16], zero = (acc[15:0]==0). Set out_valid and return to IDLE.
  - Operands are unsigned.
- Output hold: while out_valid && !out_ready, result, zero and overflow are frozen and in_ready = 0.
- out_valid clears on an edge with out_ready, unless a new single-cycle op is accepted on the same edge, in which case out_valid stays 1 with the new values.
- zero always reflects the registered result.

## Timing
- Reset (asynchronous, reset_n low): state=IDLE, out_valid=0, result=0, zero=0, overflow=0, count=0. in_ready=0 while reset_n is low.
- Reset during MUL aborts the multiply; no out_valid is produced.
- Single-cycle op latency: out_valid rises on the accept edge and is visible the following cycle. Throughput is 1 op/cycle when out_ready is held high.
- mul latency: 16 edges after the accept edge, out_valid=1. in_ready=0 for those cycles and until the result is taken.
- Back-to-back: a new op may be accepted on the same edge the previous result is consumed.
- in_valid while in_ready=0 is ignored. The requester must hold in_valid and data until accepted.

## Configuration
- MULT_EN defined:
  - Code 101 starts the 16-cycle multiply described above.
  - The MUL state, counter and shift registers exist.
- MULT_EN undefined:
  - Code 101 executes as add (single cycle).
  - No MUL state or counter is synthesized; the FSM reduces to IDLE only.

## Test plan
- Reset: assert reset_n=0 mid-stream -> out_valid=0, result=0, zero=0, overflow=0, in_ready=0. Release -> in_ready=1.
- Add/sub overflow: add 16'h7FFF+16'h0001 -> result 16'h8000, overflow=1. Then sub 16'h0005-16'h0005 -> result 0, zero=1, overflow=0, one result per cycle with out_ready=1.
- slt signed: a=16'hFFFF, b=16'h0001 -> result 16'h0001. Swapped operands -> result 16'h0000, zero=1.
- Backpressure: issue and with out_ready=0 for 3 cycles -> result held, in_ready=0. Raise out_ready together with in_valid (or) -> or accepted on the same edge, out_valid remains 1.
- Multiply (MULT_EN): 16'h0123*16'h0010 -> out_valid after 16 cycles, result 16'h1230, overflow=0. 16'h0100*16'h0100 -> result 0, zero=1, overflow=1. Without MULT_EN, code 101 with 3,4 -> result 7 after 1 cycle.
- Reset mid-multiply: drop reset_n at MUL cycle 8 -> no out_valid. After release, a new add 2+2 returns 4 with normal latency.
